// File: rtl/matrix_pkg.sv
// Shared constants, fetch state encoding and SRAM address packing for the matrix presenter path.
package matrix_pkg;

    localparam int MAX_COLUMNS     = 768;
    localparam int MAX_ROWS        = 32;
    localparam int PIXELS_PER_WORD = 4;
    localparam int WORDS_PER_LINE  = MAX_COLUMNS / PIXELS_PER_WORD;
    localparam int NUM_PANES       = 4;
    localparam int ROW_W           = $clog2(MAX_ROWS);
    localparam int PANE_W          = $clog2(NUM_PANES);
    localparam int SRAM_LINE_AW    = 1 + PANE_W + 1 + ROW_W + 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_t;

    // Frame bank on top, then bit-plane, half, row and word index.
    function automatic logic [SRAM_LINE_AW-1:0] build_sram_addr(
        input logic              frame,
        input logic [PANE_W-1:0] pane,
        input logic              half,
        input logic [ROW_W-1:0]  row,
        input logic [7:0]        word
    );
        return {frame, pane, half, row, word};
    endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// Half-line buffer: one write port, one registered read port; reads past DEPTH return zero.
module line_buffer_ram #(
    parameter int DEPTH = 192,
    parameter int AW    = 8,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [DW-1:0] mem_r [DEPTH];

    // Storage write; contents are left unreset.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr <= LAST_ADDR)) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read with zero for out-of-range addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_addr <= LAST_ADDR) begin
            rd_data <= mem_r[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/matrix_line_fetcher.sv
// Fetches one bit-plane row (upper and lower half) from async SRAM into the line buffers
// on a presenter request; latches the frame bank at the first row/pane of a frame.
module matrix_line_fetcher
    import matrix_pkg::*;
#(
    parameter int WORDS_PER_LINE = matrix_pkg::WORDS_PER_LINE,
    parameter int SRAM_WAIT      = 1,
    parameter int ADDR_W         = 20
) (
    input  logic              clk66,
    input  logic              reset_n,
    input  logic              requestNewLine,
    output logic              requestInProgress,
    input  logic [4:0]        currentRow,
    input  logic [1:0]        currentPane,
    input  logic              frameSelect,
    input  logic [7:0]        rowBufferAddress,
    output logic [15:0]       colorData1,
    output logic [15:0]       colorData2,
    output logic [ADDR_W-1:0] sramAddr,
    input  logic [15:0]       sramData,
    output logic              sramCE_n,
    output logic              sramOE_n
);

    localparam logic [7:0] LAST_WORD = 8'(WORDS_PER_LINE - 1);
    localparam logic [2:0] WAIT_LAST = 3'(SRAM_WAIT);

    fetch_state_t state_r;
    fetch_state_t state_next_s;

    logic       armed_r;
    logic       latched_frame_r;
    logic [4:0] row_r;
    logic [1:0] pane_r;
    logic       half_r;
    logic [7:0] word_r;
    logic [2:0] wait_r;

    logic       accept_s;
    logic       word_done_s;
    logic       last_word_s;
    logic       half_next_s;
    logic [7:0] word_next_s;
    logic       frame_start_s;
    logic       frame_eff_s;
    logic       wr_upper_s;
    logic       wr_lower_s;

    assign frame_start_s = (currentRow == 5'd0) && (currentPane == 2'd0);
    assign frame_eff_s   = frame_start_s ? frameSelect : latched_frame_r;
    assign wr_upper_s    = word_done_s && !half_r;
    assign wr_lower_s    = word_done_s && half_r;

    // Next-state and word/half sequencing.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        word_done_s  = 1'b0;
        last_word_s  = 1'b0;
        word_next_s  = word_r;
        half_next_s  = half_r;
        case (state_r)
            ST_IDLE: begin
                if (requestNewLine && armed_r) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_READ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (wait_r == WAIT_LAST) begin
                    word_done_s = 1'b1;
                    if (word_r == LAST_WORD) begin
                        word_next_s = 8'd0;
                        if (half_r) begin
                            last_word_s  = 1'b1;
                            state_next_s = ST_DONE;
                        end else begin
                            half_next_s = 1'b1;
                        end
                    end else begin
                        word_next_s = word_r + 8'd1;
                    end
                end else begin
                    state_next_s = ST_READ;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk66 or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Re-arm only after the request has been seen low, so a held request fetches once.
    always_ff @(posedge clk66 or negedge reset_n) begin
        if (!reset_n) begin
            armed_r <= 1'b1;
        end else if (!requestNewLine) begin
            armed_r <= 1'b1;
        end else if (accept_s) begin
            armed_r <= 1'b0;
        end else begin
            armed_r <= armed_r;
        end
    end

    // Fetch datapath and registered SRAM strobes.
    always_ff @(posedge clk66 or negedge reset_n) begin
        if (!reset_n) begin
            latched_frame_r   <= 1'b0;
            row_r             <= 5'd0;
            pane_r            <= 2'd0;
            half_r            <= 1'b0;
            word_r            <= 8'd0;
            wait_r            <= 3'd0;
            requestInProgress <= 1'b0;
            sramCE_n          <= 1'b1;
            sramOE_n          <= 1'b1;
            sramAddr          <= '0;
        end else if (accept_s) begin
            row_r             <= currentRow;
            pane_r            <= currentPane;
            half_r            <= 1'b0;
            word_r            <= 8'd0;
            wait_r            <= 3'd0;
            requestInProgress <= 1'b1;
            sramCE_n          <= 1'b0;
            sramOE_n          <= 1'b0;
            sramAddr          <= ADDR_W'(build_sram_addr(frame_eff_s, currentPane, 1'b0,
                                                          currentRow, 8'd0));
            if (frame_start_s) begin
                latched_frame_r <= frameSelect;
            end
        end else if (state_r == ST_READ) begin
            if (word_done_s) begin
                wait_r <= 3'd0;
                word_r <= word_next_s;
                half_r <= half_next_s;
                if (last_word_s) begin
                    sramCE_n <= 1'b1;
                    sramOE_n <= 1'b1;
                end else begin
                    sramAddr <= ADDR_W'(build_sram_addr(latched_frame_r, pane_r, half_next_s,
                                                         row_r, word_next_s));
                end
            end else begin
                wait_r <= wait_r + 3'd1;
            end
        end else if (state_r == ST_DONE) begin
            requestInProgress <= 1'b0;
            sramCE_n          <= 1'b1;
            sramOE_n          <= 1'b1;
        end
    end

    line_buffer_ram #(
        .DEPTH (WORDS_PER_LINE),
        .AW    (8),
        .DW    (16)
    ) u_upper (
        .clk     (clk66),
        .rst_n   (reset_n),
        .wr_en   (wr_upper_s),
        .wr_addr (word_r),
        .wr_data (sramData),
        .rd_addr (rowBufferAddress),
        .rd_data (colorData1)
    );

    line_buffer_ram #(
        .DEPTH (WORDS_PER_LINE),
        .AW    (8),
        .DW    (16)
    ) u_lower (
        .clk     (clk66),
        .rst_n   (reset_n),
        .wr_en   (wr_lower_s),
        .wr_addr (word_r),
        .wr_data (sramData),
        .rd_addr (rowBufferAddress),
        .rd_data (colorData2)
    );

endmodule

// File: tb/tb_matrix_line_fetcher.sv
// Randomized scoreboard bench for matrix_line_fetcher (default wait and a SRAM_WAIT=3 instance).
module tb_matrix_line_fetcher;

    localparam int W  = 192;
    localparam int S  = 1;
    localparam int S3 = 3;

    logic        clk66 = 1'b0;
    logic        reset_n;
    logic        requestNewLine;
    logic        req3;
    logic [4:0]  currentRow;
    logic [1:0]  currentPane;
    logic        frameSelect;
    logic [7:0]  rowBufferAddress;

    logic        rip, rip3;
    logic [15:0] colorData1, colorData2, c1_3, c2_3;
    logic [19:0] sramAddr, addr3;
    logic [15:0] sramData, data3;
    logic        sramCE_n, sramOE_n, ce3_n, oe3_n;
    logic [1:0]  hold3 = 2'd0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          len;
        logic [19:0] a_up;
        logic [19:0] a_lo;
    } fetch_exp_t;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d1;
        logic [15:0] d2;
    } rd_exp_t;

    fetch_exp_t  fq[$];
    rd_exp_t     rq[$];
    logic [15:0] mbuf [2][W];
    bit          m_frame = 1'b0;
    logic        rd_issue = 1'b0;
    logic        rd_valid = 1'b0;
    int          r3 = 0;
    int          p3 = 0;

    always #5 clk66 = ~clk66;

    // Async SRAM models: plain one returns the address; slow one is only correct on the 4th cycle.
    assign sramData = sramAddr[15:0];
    assign data3    = (hold3 == 2'd3) ? addr3[15:0] : ~addr3[15:0];
    always @(posedge clk66) hold3 <= ce3_n ? 2'd0 : hold3 + 2'd1;
    always @(posedge clk66) rd_valid <= rd_issue;

    matrix_line_fetcher dut (
        .clk66 (clk66), .reset_n (reset_n), .requestNewLine (requestNewLine),
        .requestInProgress (rip), .currentRow (currentRow), .currentPane (currentPane),
        .frameSelect (frameSelect), .rowBufferAddress (rowBufferAddress),
        .colorData1 (colorData1), .colorData2 (colorData2), .sramAddr (sramAddr),
        .sramData (sramData), .sramCE_n (sramCE_n), .sramOE_n (sramOE_n)
    );

    matrix_line_fetcher #(.SRAM_WAIT (S3)) dut3 (
        .clk66 (clk66), .reset_n (reset_n), .requestNewLine (req3),
        .requestInProgress (rip3), .currentRow (currentRow), .currentPane (currentPane),
        .frameSelect (frameSelect), .rowBufferAddress (rowBufferAddress),
        .colorData1 (c1_3), .colorData2 (c2_3), .sramAddr (addr3),
        .sramData (data3), .sramCE_n (ce3_n), .sramOE_n (oe3_n)
    );

    function automatic logic [19:0] mk_addr(input int f, input int pane, input int half,
                                            input int row, input int word);
        return 20'(f * 65536 + pane * 16384 + half * 8192 + row * 256 + word);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_rip(input logic lvl, input int budget, input string nm);
        int n = 0;
        while (rip !== lvl && n < budget) begin
            @(posedge clk66); #1;
            n++;
        end
        chk(nm, 32'(rip), 32'(lvl));
    endtask

    task automatic fetch(input int row, input int pane, input bit fs, input bit hold_after);
        fetch_exp_t  e;
        logic [19:0] t;
        @(posedge clk66); #1;
        currentRow     = 5'(row);
        currentPane    = 2'(pane);
        frameSelect    = fs;
        requestNewLine = 1'b1;
        if (row == 0 && pane == 0) m_frame = fs;
        e.len  = 2 * W * (S + 1) + 1;
        e.a_up = mk_addr(int'(m_frame), pane, 0, row, 0);
        e.a_lo = mk_addr(int'(m_frame), pane, 1, row, 0);
        fq.push_back(e);
        for (int h = 0; h < 2; h++) begin
            for (int w = 0; w < W; w++) begin
                t = mk_addr(int'(m_frame), pane, h, row, w);
                mbuf[h][w] = t[15:0];
            end
        end
        wait_rip(1'b1, 10, "fetch_start");
        currentRow  = 5'($urandom);
        currentPane = 2'($urandom);
        frameSelect = 1'($urandom);
        wait_rip(1'b0, 2000, "fetch_end");
        if (!hold_after) requestNewLine = 1'b0;
    endtask

    task automatic do_reads(input int n);
        rd_exp_t    r;
        logic [7:0] a;
        for (int i = 0; i < n + 3; i++) begin
            if (i == 0)      a = 8'd7;
            else if (i == 1) a = 8'd192;
            else if (i == 2) a = 8'd255;
            else             a = 8'($urandom_range(0, 199));
            @(posedge clk66); #1;
            rowBufferAddress = a;
            rd_issue         = 1'b1;
            r.a  = a;
            r.d1 = (int'(a) < W) ? mbuf[0][a] : 16'h0000;
            r.d2 = (int'(a) < W) ? mbuf[1][a] : 16'h0000;
            rq.push_back(r);
        end
        @(posedge clk66); #1;
        rd_issue = 1'b0;
        @(posedge clk66); #1;
    endtask

    // Fetch monitor: measures each requestInProgress pulse and the first upper/lower addresses.
    int          fc = 0;
    bit          in_fetch = 1'b0;
    logic [19:0] seen_up, seen_lo;
    always @(negedge clk66) begin
        fetch_exp_t e;
        if (!reset_n) begin
            in_fetch = 1'b0;
            fc       = 0;
        end else if (rip) begin
            in_fetch = 1'b1;
            fc++;
            if (fc == 1) seen_up = sramAddr;
            if (fc == W * (S + 1) + 1) seen_lo = sramAddr;
        end else if (in_fetch) begin
            in_fetch = 1'b0;
            if (fq.size() == 0) begin
                chk("fetch_unexpected", 32'(fc), 32'd0);
            end else begin
                e = fq.pop_front();
                chk("fetch_len", 32'(fc), 32'(e.len));
                chk("fetch_addr_upper", 32'(seen_up), 32'(e.a_up));
                chk("fetch_addr_lower", 32'(seen_lo), 32'(e.a_lo));
            end
            fc = 0;
        end
    end

    // Read monitor: one cycle after an issued address the buffer words must match the model.
    always @(negedge clk66) begin
        rd_exp_t r;
        if (rd_valid) begin
            if (rq.size() == 0) begin
                chk("read_unexpected", 32'd1, 32'd0);
            end else begin
                r = rq.pop_front();
                chk($sformatf("color1[%0d]", r.a), 32'(colorData1), 32'(r.d1));
                chk($sformatf("color2[%0d]", r.a), 32'(colorData2), 32'(r.d2));
            end
        end
    end

    // Slow-SRAM monitor: each address must be held SRAM_WAIT+1 cycles, pulse length checked at end.
    int c3 = 0;
    always @(negedge clk66) begin
        int idx;
        if (!reset_n) begin
            c3 = 0;
        end else if (rip3) begin
            c3++;
            if (c3 <= 2 * W * (S3 + 1)) begin
                idx = (c3 - 1) / (S3 + 1);
                chk("w3_addr", 32'(addr3), 32'(mk_addr(0, p3, idx / W, r3, idx % W)));
            end
        end else if (c3 > 0) begin
            chk("w3_len", 32'(c3), 32'(2 * W * (S3 + 1) + 1));
            c3 = 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_hi;
        int          row, pane;
        logic [19:0] t;
        reset_n          = 1'b0;
        requestNewLine   = 1'b0;
        req3             = 1'b0;
        currentRow       = 5'd0;
        currentPane      = 2'd0;
        frameSelect      = 1'b0;
        rowBufferAddress = 8'd0;
        #23;
        chk("rst_rip", 32'(rip), 32'd0);
        chk("rst_ce", 32'(sramCE_n), 32'd1);
        chk("rst_oe", 32'(sramOE_n), 32'd1);
        chk("rst_addr", 32'(sramAddr), 32'd0);
        chk("rst_color", 32'({colorData1, colorData2}), 32'd0);
        @(posedge clk66); #1;
        reset_n = 1'b1;

        fetch(5, 2, 1'b0, 1'b0);
        do_reads(8);

        // Request held high after completion must not start a second fetch.
        fetch(11, 3, 1'b0, 1'b1);
        n_hi = 0;
        repeat (800) begin
            @(posedge clk66); #1;
            if (rip) n_hi++;
        end
        chk("no_refetch", 32'(n_hi), 32'd0);
        requestNewLine = 1'b0;

        fetch(3, 1, 1'b1, 1'b0);
        fetch(0, 0, 1'b1, 1'b0);
        fetch($urandom_range(1, 31), $urandom_range(0, 3), 1'b0, 1'b0);
        do_reads(8);

        // Reset in the middle of the upper half.
        @(posedge clk66); #1;
        currentRow     = 5'd9;
        currentPane    = 2'd1;
        requestNewLine = 1'b1;
        wait_rip(1'b1, 10, "abort_start");
        repeat (2 * 100) @(posedge clk66);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_rip", 32'(rip), 32'd0);
        chk("abort_ce_oe", 32'({sramCE_n, sramOE_n}), 32'd3);
        chk("abort_color", 32'({colorData1, colorData2}), 32'd0);
        @(posedge clk66); #1;
        reset_n        = 1'b1;
        requestNewLine = 1'b0;
        m_frame        = 1'b0;
        fetch(9, 1, 1'b0, 1'b0);
        do_reads(6);

        for (int k = 0; k < 3; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                row  = 0;
                pane = 0;
            end else begin
                row  = $urandom_range(0, 31);
                pane = $urandom_range(0, 3);
            end
            fetch(row, pane, 1'($urandom), 1'b0);
            do_reads(10);
        end

        // Slow SRAM instance: data valid only on the last cycle of each read.
        r3 = $urandom_range(1, 31);
        p3 = $urandom_range(0, 3);
        @(posedge clk66); #1;
        currentRow  = 5'(r3);
        currentPane = 2'(p3);
        frameSelect = 1'b0;
        req3        = 1'b1;
        n_hi = 0;
        while (!rip3 && n_hi < 10) begin @(posedge clk66); #1; n_hi++; end
        chk("w3_start", 32'(rip3), 32'd1);
        n_hi = 0;
        while (rip3 && n_hi < 3000) begin @(posedge clk66); #1; n_hi++; end
        chk("w3_end", 32'(rip3), 32'd0);
        req3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int a;
            a = (i == 0) ? 7 : ((i == 1) ? W - 1 : $urandom_range(0, W - 1));
            @(posedge clk66); #1;
            rowBufferAddress = 8'(a);
            @(posedge clk66); #1;
            t = mk_addr(0, p3, 0, r3, a);
            chk("w3_color1", 32'(c1_3), 32'(t[15:0]));
            t = mk_addr(0, p3, 1, r3, a);
            chk("w3_color2", 32'(c2_3), 32'(t[15:0]));
        end

        repeat (4) @(posedge clk66);
        chk("fetch_queue_empty", 32'(fq.size()), 32'd0);
        chk("read_queue_empty", 32'(rq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
